// File: rtl/psum_pkg.sv
// Shared constants, mode encodings and FSM state type for the partial-sum readout.
package psum_pkg;

  localparam int SUM_W    = 8;
  localparam int RES_W    = 20;
  localparam int NCYC_INT = 8;

  localparam logic [2:0] MODE_FP16 = 3'b000;
  localparam logic [2:0] MODE_FP8  = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic is_fp_mode(input logic [2:0] m);
    return (m == MODE_FP16) || (m == MODE_FP8);
  endfunction

endpackage

// File: rtl/psum_readout_sat.sv
// psum_sat: combinational clamp of a RES_W-bit signed value to the signed 16-bit range.
module psum_sat
  import psum_pkg::*;
(
  input  logic signed [RES_W-1:0] value_i,
  output logic signed [RES_W-1:0] value_o,
  output logic                    sat_o
);

  localparam logic signed [RES_W-1:0] SAT_MAX = RES_W'(32767);
  localparam logic signed [RES_W-1:0] SAT_MIN = RES_W'(-32768);

  always_comb begin
    value_o = value_i;
    sat_o   = 1'b0;
    if (value_i > SAT_MAX) begin
      value_o = SAT_MAX;
      sat_o   = 1'b1;
    end else if (value_i < SAT_MIN) begin
      value_o = SAT_MIN;
      sat_o   = 1'b1;
    end
  end

endmodule

// File: rtl/psum_readout.sv
// Reconstructs a dot product from pos/neg column counts (FP sign or INT bit-serial planes).
// Optional output clamping is enabled by defining PSUM_SAT_EN.
module psum_readout
  import psum_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [2:0]              mode,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic [SUM_W-1:0]        pos_sum,
  input  logic [SUM_W-1:0]        neg_sum,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic signed [RES_W-1:0] result,
  output logic                    sat,
  output logic                    busy
);

  localparam logic [2:0] K_LAST = 3'(NCYC_INT - 1);

  state_e                  state_q, state_d;
  logic [2:0]              mode_q, mode_d;
  logic [2:0]              k_q, k_d;
  logic signed [RES_W-1:0] acc_q, acc_d;
  logic signed [RES_W-1:0] result_q, result_d;
  logic                    sat_q, sat_d;

  logic signed [SUM_W:0]   diff;
  logic signed [RES_W-1:0] diff_ext;
  logic signed [RES_W-1:0] plane_term;
  logic signed [RES_W-1:0] acc_sum;
  logic signed [RES_W-1:0] final_res;
  logic                    final_sat;
  logic                    fp_mode;
  logic                    last_sample;

  assign diff       = $signed({1'b0, pos_sum}) - $signed({1'b0, neg_sum});
  assign diff_ext   = {{(RES_W - SUM_W - 1){diff[SUM_W]}}, diff};
  assign plane_term = diff_ext <<< k_q;
  assign fp_mode    = is_fp_mode(mode_q);
  assign last_sample = fp_mode || (k_q == K_LAST);

  // MSB plane carries negative weight in two's complement
  always_comb begin
    acc_sum = acc_q + plane_term;
    if (fp_mode) begin
      acc_sum = diff_ext;
    end else if (k_q == K_LAST) begin
      acc_sum = acc_q - plane_term;
    end
  end

`ifdef PSUM_SAT_EN
  psum_sat u_sat (
    .value_i (acc_sum),
    .value_o (final_res),
    .sat_o   (final_sat)
  );
`else
  assign final_res = acc_sum;
  assign final_sat = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_FP16;
      k_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      sat_q    <= sat_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    k_d      = k_q;
    acc_d    = acc_q;
    result_d = result_q;
    sat_d    = sat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ACCUM;
          mode_d  = mode;
          acc_d   = '0;
          k_d     = '0;
        end
      end
      ST_ACCUM: begin
        if (in_valid) begin
          acc_d = acc_sum;
          k_d   = k_q + 3'd1;
          if (last_sample) begin
            state_d  = ST_DONE;
            result_d = final_res;
            sat_d    = final_sat;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
    result    = result_q;
    sat       = sat_q;
  end

endmodule
